// File: rtl/risc16_io_pkg.sv
// Shared definitions for the risc16 memory-mapped I/O block: register map,
// STATUS bit positions and the UART transmitter state encoding.
package risc16_io_pkg;

  localparam logic [11:0] IO_PAGE     = 12'h020;
  localparam logic [15:0] IO_BASE     = 16'h0200;
  localparam logic [15:0] ADDR_LED01  = 16'h0200;
  localparam logic [15:0] ADDR_LED2   = 16'h0202;
  localparam logic [15:0] ADDR_CYCLE  = 16'h0204;
  localparam logic [15:0] ADDR_TXDATA = 16'h0206;
  localparam logic [15:0] ADDR_STATUS = 16'h0208;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/risc16_uart_tx.sv
// 8N1 UART transmitter; accepts a byte on valid & ready (ready only in IDLE).
module risc16_uart_tx
  import risc16_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] CPB_M1 = 16'(CLKS_PER_BIT - 1);

  uart_state_t r_state, w_state;
  logic [15:0] r_clk_cnt, w_clk_cnt;
  logic [2:0]  r_bit_cnt, w_bit_cnt;
  logic [7:0]  r_shift, w_shift;
  logic        w_bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state;
      r_clk_cnt <= w_clk_cnt;
      r_bit_cnt <= w_bit_cnt;
      r_shift   <= w_shift;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_clk_cnt = r_clk_cnt;
    w_bit_cnt = r_bit_cnt;
    w_shift   = r_shift;
    w_bit_end = (r_clk_cnt == CPB_M1);
    ready     = 1'b0;
    tx        = 1'b1;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          w_shift   = data;
          w_bit_cnt = '0;
          w_clk_cnt = '0;
          w_state   = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (w_bit_end) begin
          w_clk_cnt = '0;
          w_state   = DATA;
        end else begin
          w_clk_cnt = r_clk_cnt + 16'd1;
        end
      end
      DATA: begin
        tx = r_shift[0];
        if (w_bit_end) begin
          w_clk_cnt = '0;
          w_shift   = {1'b0, r_shift[7:1]};
          w_bit_cnt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state = STOP;
        end else begin
          w_clk_cnt = r_clk_cnt + 16'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_clk_cnt = '0;
          w_state   = IDLE;
        end else begin
          w_clk_cnt = r_clk_cnt + 16'd1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

endmodule

// File: rtl/risc16_io.sv
// Memory-mapped I/O window 0x200-0x20F: LED registers, cycle counter and a
// transmit FIFO feeding the UART transmitter.
module risc16_io
  import risc16_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe0,
  input  logic        dwe1,
  output logic        io_sel,
  output logic [15:0] io_rdata,
  output logic [23:0] led,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_led0, r_led1, r_led2;
  logic [15:0]   r_cycle;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [15:0] w_addr;
  logic        w_we0, w_we1;
  logic        w_hit_led01, w_hit_led2, w_hit_cycle, w_hit_tx, w_hit_status;
  logic        w_full, w_empty, w_ready, w_pop;
  logic        w_push, w_push_ok, w_ovf_set, w_ovf_clr;
  logic [3:0]  w_status;

  assign io_sel       = (daddr[15:4] == IO_PAGE);
  assign w_addr       = daddr & 16'hfffe;
  assign w_we0        = io_sel & dwe0;
  assign w_we1        = io_sel & dwe1;
  assign w_hit_led01  = (w_addr == ADDR_LED01);
  assign w_hit_led2   = (w_addr == ADDR_LED2);
  assign w_hit_cycle  = (w_addr == ADDR_CYCLE);
  assign w_hit_tx     = (w_addr == ADDR_TXDATA);
  assign w_hit_status = (w_addr == ADDR_STATUS);

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = ~w_empty & w_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push    = w_we1 & w_hit_tx;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & ~w_push_ok;
  assign w_ovf_clr = w_we1 & w_hit_status & ddout[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led0 <= '0;
      r_led1 <= '0;
      r_led2 <= '0;
    end else begin
      if (w_we0 && w_hit_led01) r_led1 <= ddout[15:8];
      if (w_we1 && w_hit_led01) r_led0 <= ddout[7:0];
      if (w_we1 && w_hit_led2)  r_led2 <= ddout[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cycle <= '0;
    else if ((w_we0 || w_we1) && w_hit_cycle) r_cycle <= '0;
    else r_cycle <= r_cycle + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= ddout[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  risc16_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .valid(~w_empty),
    .data (r_fifo[r_rd_ptr]),
    .ready(w_ready),
    .tx   (tx)
  );

  always_comb begin
    w_status           = '0;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_BUSY]  = ~w_ready;
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    io_rdata = '0;
    if (io_sel && doe) begin
      case (w_addr)
        ADDR_LED01:  io_rdata = {r_led1, r_led0};
        ADDR_LED2:   io_rdata = {8'h00, r_led2};
        ADDR_CYCLE:  io_rdata = r_cycle;
        ADDR_TXDATA: io_rdata = {8'h00, 8'(r_count)};
        ADDR_STATUS: io_rdata = {12'h000, w_status};
        default:     io_rdata = '0;
      endcase
    end
  end

  assign led = {r_led2, r_led1, r_led0};

endmodule

// File: tb/tb_risc16_io.sv
// Directed self-checking bench for risc16_io with a 4-cycle UART bit period.
module tb_risc16_io;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] daddr = '0;
  logic [15:0] ddout = '0;
  logic        doe = 1'b0;
  logic        dwe0 = 1'b0;
  logic        dwe1 = 1'b0;
  logic        io_sel;
  logic [15:0] io_rdata;
  logic [23:0] led;
  logic        tx;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  risc16_io #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .daddr   (daddr),
    .ddout   (ddout),
    .doe     (doe),
    .dwe0    (dwe0),
    .dwe1    (dwe1),
    .io_sel  (io_sel),
    .io_rdata(io_rdata),
    .led     (led),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    daddr = a;
    doe   = 1'b1;
    #1;
    chk(tag, {16'h0, io_rdata}, {16'h0, exp});
    doe = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic we0, input logic we1);
    daddr = a;
    ddout = d;
    dwe0  = we0;
    dwe1  = we1;
    @(posedge clk);
    #1;
    dwe0 = 1'b0;
    dwe1 = 1'b0;
  endtask

  // First sample is taken in the first cycle after the pop edge.
  task automatic chk_frame(input string tag, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("%s_c%0d", tag, i), {31'h0, tx}, {31'h0, frame[i/4]});
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_led", {8'h0, led}, 32'h0);
    daddr = 16'h0205;
    #1;
    chk("rst_iosel_in", {31'h0, io_sel}, 32'h1);
    chk("rst_rdata_noe", {16'h0, io_rdata}, 32'h0);
    daddr = 16'h0210;
    #1;
    chk("rst_iosel_out", {31'h0, io_sel}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_rd("cycle_first", 16'h0204, 16'h0001);
    chk_rd("status_rst", 16'h0208, 16'h0002);

    // LED registers
    wr(16'h0200, 16'hA55A, 1'b1, 1'b1);
    wr(16'h0202, 16'h003C, 1'b0, 1'b1);
    chk("led_val", {8'h0, led}, 32'h003CA55A);
    chk_rd("rd_led2", 16'h0202, 16'h003C);
    chk_rd("rd_led01_alias", 16'h0201, 16'hA55A);
    wr(16'h0202, 16'hFF77, 1'b1, 1'b0);
    chk("led2_dwe0_ign", {8'h0, led}, 32'h003CA55A);
    wr(16'h0100, 16'h1111, 1'b1, 1'b1);
    chk("led_nosel", {8'h0, led}, 32'h003CA55A);
    wr(16'h0200, 16'h5500, 1'b1, 1'b0);
    chk("led1_only", {8'h0, led}, 32'h003C555A);
    chk_rd("rd_unlisted", 16'h020A, 16'h0000);

    // Cycle counter clear and wrap
    wr(16'h0204, 16'h1234, 1'b1, 1'b0);
    chk_rd("cycle_clr", 16'h0204, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk_rd("cycle_plus2", 16'h0204, 16'h0002);
    wr(16'h0204, 16'h0000, 1'b0, 1'b1);
    repeat (65535) @(posedge clk);
    #1;
    chk_rd("cycle_ffff", 16'h0204, 16'hFFFF);
    @(posedge clk);
    #1;
    chk_rd("cycle_wrap", 16'h0204, 16'h0000);

    // Single frame 0x53
    wr(16'h0206, 16'h0053, 1'b0, 1'b1);
    chk("pre_pop_tx", {31'h0, tx}, 32'h1);
    chk_rd("pre_pop_cnt", 16'h0206, 16'h0001);
    @(posedge clk);
    #1;
    chk_frame("f53", 8'h53);
    @(posedge clk);
    #1;
    chk("f53_idle_tx", {31'h0, tx}, 32'h1);
    chk_rd("f53_idle_status", 16'h0208, 16'h0002);

    // Overflow: six pushes, one popped immediately, sixth dropped
    wr(16'h0206, 16'h0011, 1'b0, 1'b1);
    wr(16'h0206, 16'h0022, 1'b0, 1'b1);
    wr(16'h0206, 16'h0033, 1'b0, 1'b1);
    wr(16'h0206, 16'h0044, 1'b0, 1'b1);
    wr(16'h0206, 16'h0055, 1'b0, 1'b1);
    wr(16'h0206, 16'h0066, 1'b0, 1'b1);
    chk_rd("ovf_status", 16'h0208, 16'h000D);
    chk_rd("ovf_count", 16'h0206, 16'h0004);
    wr(16'h0208, 16'h0008, 1'b0, 1'b1);
    chk_rd("ovf_cleared", 16'h0208, 16'h0005);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_rd("rst2_status", 16'h0208, 16'h0002);

    // Back-to-back frames with one idle cycle between
    wr(16'h0206, 16'h00A1, 1'b0, 1'b1);
    wr(16'h0206, 16'h003C, 1'b0, 1'b1);
    chk("b2b_start_tx", {31'h0, tx}, 32'h0);
    chk_rd("b2b_status1", 16'h0208, 16'h0004);
    chk_frame("fA1", 8'hA1);
    @(posedge clk);
    #1;
    chk("b2b_gap_tx", {31'h0, tx}, 32'h1);
    chk_rd("b2b_gap_status", 16'h0208, 16'h0000);
    @(posedge clk);
    #1;
    chk_rd("b2b_status2", 16'h0208, 16'h0006);
    chk_frame("f3C", 8'h3C);
    @(posedge clk);
    #1;
    chk_rd("b2b_end_status", 16'h0208, 16'h0002);

    // Reset during data bit 3
    wr(16'h0200, 16'h1234, 1'b1, 1'b1);
    wr(16'h0206, 16'h0000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    repeat (17) @(posedge clk);
    #1;
    chk("bit3_tx", {31'h0, tx}, 32'h0);
    chk_rd("bit3_status", 16'h0208, 16'h0006);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", {31'h0, tx}, 32'h1);
    chk("rst_mid_led", {8'h0, led}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_rd("rst_mid_status", 16'h0208, 16'h0002);
    chk_rd("rst_mid_led01", 16'h0200, 16'h0000);
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_tx", {31'h0, tx}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/risc16_io.md
# risc16_io

Memory-mapped I/O block on the risc16ba data port, downstream of the CPU's data-side bus and in parallel with data memory. Decodes word addresses 0x200–0x20F and provides:
- three 8-bit LED registers,
- a free-running 16-bit cycle counter,
- a 4-entry transmit FIFO feeding an 8N1 UART transmitter.

Asserts `io_sel` so the memory model suppresses its own access for this window.

## Interface
- `CLKS_PER_BIT`, default 217: UART bit period in clk cycles (25 MHz / 115200); legal range 2–65535.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, at least 2.

Ports:
- `clk` input, 1: system clock; all state updates on the rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `daddr` input, 16: CPU data address.
- `ddout` input, 16: CPU write data; [15:8] is the even byte, [7:0] the odd byte.
- `doe` input, 1: CPU read enable.
- `dwe0` input, 1: write enable, even byte lane (ddout[15:8]).
- `dwe1` input, 1: write enable, odd byte lane (ddout[7:0]).
- `io_sel` output, 1: daddr[15:4] == 12'h020; combinational.
- `io_rdata` output, 16: read data; combinational, valid when io_sel & doe, else 16'h0000.
- `led` output, 24: {led_2, led_1, led_0}.
- `tx` output, 1: UART serial out; idle high.

## Operation
Register map. Decode uses daddr & 16'hfffe; unlisted offsets read 0 and ignore writes.
- 0x200 LED01:
  - dwe0 writes led_1 <= ddout[15:8]; dwe1 writes led_0 <= ddout[7:0].
  - Read {led_1, led_0}.
- 0x202 LED2:
  - dwe1 writes led_2 <= ddout[7:0]; dwe0 ignored.
  - Read {8'h00, led_2}.
- 0x204 CYCLE:
  - Increments every cycle, wraps FFFF→0000.
  - A write on either lane loads 0; the write wins over the increment.
  - Read returns the current value.
- 0x206 TXDATA:
  - dwe1 pushes ddout[7:0] into the FIFO.
  - Read {8'h00, fifo_count (zero-extended)}.
- 0x208 STATUS:
  - Read {12'h0, ovf, busy, empty, full}.
  - dwe1 with ddout[3]=1 clears ovf.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle; count is then unchanged.
  - Otherwise the byte is dropped and ovf sets (sticky).
  - If set and clear of ovf coincide, set wins.
- UART FSM (IDLE, START, DATA, STOP):
  - IDLE: tx=1. If the FIFO is non-empty, pop into shift register, bit_cnt=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit. After the 8th bit go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy = (state != IDLE).

## Timing
- Reset values:
  - led=24'h0, CYCLE=0, FIFO empty, ovf=0, state=IDLE.
  - tx=1, io_rdata=0, io_sel follows daddr.
- Writes take effect at the rising edge where dwe0/dwe1 is high and io_sel=1; visible on io_rdata the next cycle.
- Reads are zero-latency combinational, matching the CPU's same-cycle ddin sampling.
- CYCLE read in cycle N shows the value registered at edge N. After reset release, the first edge yields 1.
- Frame timing:
  - Pop occurs at the edge leaving IDLE; tx falls in the following cycle.
  - A frame is exactly 10*CLKS_PER_BIT cycles low-to-end-of-stop.
  - Back-to-back frames are separated by exactly one IDLE cycle (tx=1).
- Simultaneous dwe0/dwe1 on 0x200 updates both bytes in one edge.
- Reset asserted mid-frame forces tx=1 immediately (async), empties the FIFO and drops the frame in progress.

## Structure
- Package `risc16_io_pkg`:
  - address constants IO_BASE, ADDR_LED01, ADDR_LED2, ADDR_CYCLE, ADDR_TXDATA, ADDR_STATUS;
  - STATUS bit indices;
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `risc16_uart_tx`:
  - ports clk, rst, `valid`, `data[7:0]`, `ready` (= IDLE), `tx`;
  - the pop handshake is valid & ready.
- The FIFO and register file live in the top.

## Test plan
- Reset, then write 16'hA55A to 0x200 with dwe0=dwe1=1, then 16'h003C to 0x202 with dwe1 → led=24'h3CA55A; read 0x202 returns 16'h003C.
- Write 0x204 with dwe0 at edge N → read at N+1 returns 0x0000, N+3 returns 0x0002. Force CYCLE to FFFF → wraps to 0000.
- CLKS_PER_BIT=4; push 8'h53 → tx low 4 cycles; then bits 1,1,0,0,1,0,1,0 at 4 cycles each; high 4 cycles; frame is 40 cycles.
- Push 6 bytes in consecutive cycles while the first frame is starting → 5 accepted (one popped immediately), 6th dropped. STATUS reads ovf=1, full=1; write 0x208 with 16'h0008 → ovf=0.
- Two queued bytes → exactly one tx=1 IDLE cycle between the first stop bit and the second start bit. STATUS.empty=1 after the second pop.
- Assert rst during DATA bit 3 → tx=1 within the same cycle; STATUS=16'h0002 after release; led=0.
